// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU run/step sequencer: controller states and run modes.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      S_RESET  = 2'b00,
      S_ACTIVE = 2'b01,
      S_HALTED = 2'b10
   } ctrl_state_t;

   typedef enum logic [1:0] {
      M_FREE  = 2'b00,
      M_SLOW  = 2'b01,
      M_STEP  = 2'b10,
      M_PAUSE = 2'b11
   } run_mode_t;

endpackage

// File: rtl/cpu_run_ctrl_key_debounce.sv
// Step key conditioning: 2-FF synchronizer, stability debounce and a one-cycle
// pulse on each accepted press (falling edge of the debounced level).
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);

   logic            key_meta;
   logic            key_sync;
   logic            level;
   logic [DB_W-1:0] db_cnt;

   // Synchronizer resets to the released (high) key level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_meta <= 1'b1;
         key_sync <= 1'b1;
      end else begin
         key_meta <= key_n;
         key_sync <= key_meta;
      end
   end

   // Level is accepted only after DEBOUNCE_CYC consecutive disagreeing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level  <= 1'b1;
         db_cnt <= '0;
         press  <= 1'b0;
      end else if (key_sync != level) begin
         if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
            level  <= key_sync;
            db_cnt <= '0;
            press  <= ~key_sync;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
            press  <= 1'b0;
         end
      end else begin
         db_cnt <= '0;
         press  <= 1'b0;
      end
   end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer: produces the core clock enable (free, slow, single-step or
// paused), holds the core in reset after board reset, stops on halt, counts cycles.
module cpu_run_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned SLOW_DIV     = 50_000_000,
   parameter int unsigned DEBOUNCE_CYC = 1_000_000,
   parameter int unsigned RST_HOLD     = 4,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       mode_sel,
   input  logic             step_key_n,
   input  logic             halt_in,
   output logic             cpu_en,
   output logic             cpu_rst_n,
   output logic             halted,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int unsigned DIV_W  = $clog2(SLOW_DIV);
   localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

   ctrl_state_t       cur_state;
   ctrl_state_t       state_nxt;
   logic [1:0]        mode_meta;
   logic [1:0]        mode_sync;
   run_mode_t         mode_s;
   run_mode_t         mode_prev;
   logic              mode_chg;
   logic              press;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_nxt;
   logic [DIV_W-1:0]  div;
   logic [DIV_W-1:0]  div_nxt;
   logic              en_nxt;
   logic              rst_n_nxt;
   logic              halted_nxt;
   logic [CNT_W-1:0]  count_nxt;

   key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
   ) u_key_debounce (
      .clk   (clk),
      .rst_n (reset_n),
      .key_n (step_key_n),
      .press (press)
   );

   // Mode switches are quasi-static; a plain 2-FF synchronizer is enough.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_meta <= 2'b00;
         mode_sync <= 2'b00;
      end else begin
         mode_meta <= mode_sel;
         mode_sync <= mode_meta;
      end
   end

   assign mode_s   = run_mode_t'(mode_sync);
   assign mode_chg = (mode_s != mode_prev);
   assign state    = cur_state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_state   <= S_RESET;
         mode_prev   <= M_FREE;
         hold_cnt    <= '0;
         div         <= '0;
         cpu_en      <= 1'b0;
         cpu_rst_n   <= 1'b0;
         halted      <= 1'b0;
         cycle_count <= '0;
      end else begin
         cur_state   <= state_nxt;
         mode_prev   <= mode_s;
         hold_cnt    <= hold_nxt;
         div         <= div_nxt;
         cpu_en      <= en_nxt;
         cpu_rst_n   <= rst_n_nxt;
         halted      <= halted_nxt;
         cycle_count <= count_nxt;
      end
   end

   always_comb begin
      state_nxt  = cur_state;
      hold_nxt   = hold_cnt;
      div_nxt    = div;
      en_nxt     = 1'b0;
      rst_n_nxt  = cpu_rst_n;
      halted_nxt = halted;
      count_nxt  = cycle_count;

      // Saturating count of issued enables; a pulse coinciding with halt still counts.
      if (cpu_en && (cycle_count != '1)) begin
         count_nxt = cycle_count + CNT_W'(1);
      end

      case (cur_state)
         S_RESET: begin
            rst_n_nxt  = 1'b0;
            halted_nxt = 1'b0;
            div_nxt    = '0;
            if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
               state_nxt = S_ACTIVE;
               rst_n_nxt = 1'b1;
            end else begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
         end

         S_ACTIVE: begin
            rst_n_nxt = 1'b1;
            if (halt_in) begin
               state_nxt  = S_HALTED;
               halted_nxt = 1'b1;
               div_nxt    = '0;
            end else if (mode_chg) begin
               // Restart the divider so the first slow pulse is a full period away.
               div_nxt = '0;
               en_nxt  = (mode_s == M_FREE) || ((mode_s == M_STEP) && press);
            end else begin
               case (mode_s)
                  M_FREE: begin
                     div_nxt = '0;
                     en_nxt  = 1'b1;
                  end
                  M_SLOW: begin
                     if (div == DIV_W'(SLOW_DIV - 1)) begin
                        div_nxt = '0;
                        en_nxt  = 1'b1;
                     end else begin
                        div_nxt = div + DIV_W'(1);
                     end
                  end
                  M_STEP: begin
                     div_nxt = '0;
                     en_nxt  = press;
                  end
                  default: begin
                     div_nxt = '0;
                  end
               endcase
            end
         end

         S_HALTED: begin
            rst_n_nxt  = 1'b1;
            halted_nxt = 1'b1;
            div_nxt    = '0;
         end

         default: begin
            state_nxt  = S_RESET;
            rst_n_nxt  = 1'b0;
            halted_nxt = 1'b0;
            hold_nxt   = '0;
            div_nxt    = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: table of run-mode vectors plus hand-written
// halt, saturation and mid-operation reset sequences.
module tb_cpu_run_ctrl;
   import cpu_ctrl_pkg::*;

   logic       clk;
   logic       reset_n;
   logic [1:0] mode_sel;
   logic       step_key_n;
   logic       halt_in;
   logic       cpu_en;
   logic       cpu_rst_n;
   logic       halted;
   logic [1:0] state;
   logic [7:0] cycle_count;

   int unsigned n_vec;
   int unsigned n_err;
   int unsigned pulses;

   cpu_run_ctrl #(
      .SLOW_DIV     (4),
      .DEBOUNCE_CYC (3),
      .RST_HOLD     (4),
      .CNT_W        (8)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .mode_sel    (mode_sel),
      .step_key_n  (step_key_n),
      .halt_in     (halt_in),
      .cpu_en      (cpu_en),
      .cpu_rst_n   (cpu_rst_n),
      .halted      (halted),
      .state       (state),
      .cycle_count (cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  mode;
      logic        key_n;
      int unsigned cyc;
      int unsigned exp_pulses;
      ctrl_state_t exp_state;
      logic        exp_en;
      int unsigned exp_count;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance one clock; sample just after the edge and tally enable pulses.
   task automatic tick();
      @(posedge clk);
      #1;
      if (cpu_en) pulses++;
   endtask

   task automatic ticks(input int unsigned n);
      for (int i = 0; i < int'(n); i++) tick();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      ticks(2);
      reset_n = 1'b1;
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      pulses     = 0;
      reset_n    = 1'b0;
      mode_sel   = 2'b00;
      step_key_n = 1'b1;
      halt_in    = 1'b0;

      //          mode   key   cyc pls  state     en    count
      vecs[0]  = '{2'b00, 1'b1,  4,  0, S_ACTIVE, 1'b0,  0};
      vecs[1]  = '{2'b00, 1'b1, 11, 11, S_ACTIVE, 1'b1, 10};
      vecs[2]  = '{2'b01, 1'b1,  3,  2, S_ACTIVE, 1'b0, 13};
      vecs[3]  = '{2'b01, 1'b1, 12,  3, S_ACTIVE, 1'b1, 15};
      vecs[4]  = '{2'b01, 1'b1,  1,  0, S_ACTIVE, 1'b0, 16};
      vecs[5]  = '{2'b11, 1'b1, 10,  0, S_ACTIVE, 1'b0, 16};
      vecs[6]  = '{2'b10, 1'b1,  4,  0, S_ACTIVE, 1'b0, 16};
      vecs[7]  = '{2'b10, 1'b0,  2,  0, S_ACTIVE, 1'b0, 16};
      vecs[8]  = '{2'b10, 1'b1, 10,  0, S_ACTIVE, 1'b0, 16};
      vecs[9]  = '{2'b10, 1'b0, 10,  1, S_ACTIVE, 1'b0, 17};
      vecs[10] = '{2'b10, 1'b1, 10,  0, S_ACTIVE, 1'b0, 17};
      vecs[11] = '{2'b00, 1'b1,  4,  2, S_ACTIVE, 1'b1, 18};

      // Reset values while reset_n is held low.
      ticks(2);
      check("rst_cpu_en", 32'(cpu_en), 0);
      check("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
      check("rst_state", 32'(state), 32'(S_RESET));
      check("rst_halted", 32'(halted), 0);
      check("rst_count", 32'(cycle_count), 0);

      reset_n = 1'b1;
      ticks(3);
      check("hold_rst_n_cyc3", 32'(cpu_rst_n), 0);
      check("hold_state_cyc3", 32'(state), 32'(S_RESET));
      check("hold_en_cyc3", 32'(cpu_en), 0);
      tick();
      check("hold_rst_n_cyc4", 32'(cpu_rst_n), 1);

      // Table: vector 0 already consumed its first 4 cycles above.
      for (int v = 0; v < 12; v++) begin
         mode_sel   = vecs[v].mode;
         step_key_n = vecs[v].key_n;
         pulses     = 0;
         if (v != 0) ticks(vecs[v].cyc);
         else pulses = vecs[v].exp_pulses;
         check($sformatf("v%0d_pulses", v), pulses, vecs[v].exp_pulses);
         check($sformatf("v%0d_state", v), 32'(state), 32'(vecs[v].exp_state));
         check($sformatf("v%0d_en", v), 32'(cpu_en), 32'(vecs[v].exp_en));
         check($sformatf("v%0d_count", v), 32'(cycle_count), vecs[v].exp_count);
      end

      // Halt: ignored during reset hold, then taken with an enable in flight.
      mode_sel   = 2'b00;
      step_key_n = 1'b1;
      halt_in    = 1'b1;
      do_reset();
      ticks(3);
      halt_in = 1'b0;
      tick();
      check("halt_ign_reset_state", 32'(state), 32'(S_ACTIVE));
      ticks(6);
      check("pre_halt_count", 32'(cycle_count), 5);
      check("pre_halt_en", 32'(cpu_en), 1);
      halt_in = 1'b1;
      tick();
      check("halt_state", 32'(state), 32'(S_HALTED));
      check("halt_halted", 32'(halted), 1);
      check("halt_en", 32'(cpu_en), 0);
      check("halt_count", 32'(cycle_count), 6);
      halt_in  = 1'b0;
      mode_sel = 2'b10;
      pulses   = 0;
      step_key_n = 1'b0;
      ticks(10);
      step_key_n = 1'b1;
      ticks(10);
      check("halt_step_pulses", pulses, 0);
      check("halt_stay_state", 32'(state), 32'(S_HALTED));
      check("halt_rst_n", 32'(cpu_rst_n), 1);
      check("halt_stay_count", 32'(cycle_count), 6);

      // Saturation of the cycle counter.
      mode_sel = 2'b00;
      do_reset();
      ticks(304);
      check("sat_count", 32'(cycle_count), 255);
      check("sat_en", 32'(cpu_en), 1);
      ticks(5);
      check("sat_hold", 32'(cycle_count), 255);

      // Reset asserted mid-divide with the key mid-debounce.
      mode_sel = 2'b01;
      do_reset();
      ticks(3);
      step_key_n = 1'b0;
      ticks(3);
      check("mid_state", 32'(state), 32'(S_ACTIVE));
      reset_n = 1'b0;
      #1;
      check("mid_rst_en", 32'(cpu_en), 0);
      check("mid_rst_rst_n", 32'(cpu_rst_n), 0);
      check("mid_rst_state", 32'(state), 32'(S_RESET));
      check("mid_rst_halted", 32'(halted), 0);
      check("mid_rst_count", 32'(cycle_count), 0);
      step_key_n = 1'b1;
      mode_sel   = 2'b10;
      tick();
      reset_n = 1'b1;
      pulses  = 0;
      ticks(14);
      check("post_rst_pulses", pulses, 0);
      check("post_rst_state", 32'(state), 32'(S_ACTIVE));
      check("post_rst_count", 32'(cycle_count), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
